bridge_reg_arbiter: RTL



---
 rtl/bridge_arb_pkg.sv | 23 ++
 rtl/bridge_addr_decode.sv | 29 ++
 rtl/bridge_reg_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the APF bridge register arbiter and its slave wrappers.
package bridge_arb_pkg;

    localparam int unsigned ARB_MAX_SLAVES    = 4;
    localparam int unsigned ARB_DATA_W        = 32;
    localparam int unsigned ARB_CNT_W         = 8;
    localparam logic [31:0] ARB_UNMAPPED_DATA = 32'hFFFF_FFFF;

    typedef logic [ARB_MAX_SLAVES-1:0] slave_sel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2
    } arb_state_t;

    // Read request held while a slave read is in flight
    typedef struct packed {
        logic [ARB_DATA_W-1:0] addr;
        slave_sel_t            sel;
    } rd_req_t;

endpackage

// File: rtl/bridge_addr_decode.sv
// Region comparator and lowest-index priority select on bridge_addr[31:24].
module bridge_addr_decode
    import bridge_arb_pkg::*;
#(
    parameter int unsigned                     N_SLAVES  = 4,
    parameter logic [8*ARB_MAX_SLAVES-1:0]     REGION_LO = {8'h40, 8'h20, 8'h10, 8'hF0},
    parameter logic [8*ARB_MAX_SLAVES-1:0]     REGION_HI = {8'h4F, 8'h3F, 8'h1F, 8'hFF}
) (
    input  logic [7:0]                addr_hi,
    output logic [ARB_MAX_SLAVES-1:0] hit,
    output logic                      unmapped
);

    logic [ARB_MAX_SLAVES-1:0] in_rng;

    for (genvar g = 0; g < ARB_MAX_SLAVES; g++) begin : g_rng
        if (g < N_SLAVES) begin : g_en
            assign in_rng[g] = (addr_hi >= REGION_LO[8*g +: 8]) &&
                               (addr_hi <= REGION_HI[8*g +: 8]);
        end else begin : g_off
            assign in_rng[g] = 1'b0;
        end
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index
    assign hit      = in_rng & (~in_rng + ARB_MAX_SLAVES'(1));
    assign unmapped = ~|in_rng;

endmodule

// File: rtl/bridge_reg_arbiter.sv
// Shares the APF bridge register port between up to four register slaves:
// registered write strobes plus a read sequencer with timeout and overrun flags.
module bridge_reg_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int unsigned                 N_SLAVES      = 4,
    parameter logic [8*ARB_MAX_SLAVES-1:0] REGION_LO     = {8'h40, 8'h20, 8'h10, 8'hF0},
    parameter logic [8*ARB_MAX_SLAVES-1:0] REGION_HI     = {8'h4F, 8'h3F, 8'h1F, 8'hFF},
    parameter int unsigned                 TIMEOUT       = 255,
    parameter logic [31:0]                 UNMAPPED_DATA = ARB_UNMAPPED_DATA
) (
    input  logic                   clk_74a,
    input  logic                   reset,
    input  logic [31:0]            bridge_addr,
    input  logic                   bridge_wr,
    input  logic [31:0]            bridge_wr_data,
    input  logic                   bridge_rd,
    output logic [31:0]            bridge_rd_data,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wr_data,
    output logic [N_SLAVES-1:0]    s_wr,
    output logic [N_SLAVES-1:0]    s_rd,
    input  logic [32*N_SLAVES-1:0] s_rd_data,
    input  logic [N_SLAVES-1:0]    s_rd_valid,
    output logic                   rd_busy,
    output logic                   err_timeout,
    output logic                   err_overrun,
    input  logic                   err_clr
);

    localparam int unsigned        CNT_W       = ARB_CNT_W;
    localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    arb_state_t                state_q, state_d;
    rd_req_t                   req_q, req_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [31:0]               rd_data_d, s_addr_d, s_wr_data_d;
    logic [N_SLAVES-1:0]       s_wr_d, s_rd_d;
    logic                      rd_busy_d, err_timeout_d, err_overrun_d;
    logic                      tmo_set, ovr_set;

    logic [ARB_MAX_SLAVES-1:0] wr_hit, rd_hit;
    logic                      wr_unmapped, rd_unmapped;
    logic                      wr_go;
    logic [N_SLAVES-1:0]       sel_n;
    logic [31:0]               sel_data;
    logic                      sel_valid;

    bridge_addr_decode #(
        .N_SLAVES  (N_SLAVES),
        .REGION_LO (REGION_LO),
        .REGION_HI (REGION_HI)
    ) u_wr_decode (
        .addr_hi  (bridge_addr[31:24]),
        .hit      (wr_hit),
        .unmapped (wr_unmapped)
    );

    bridge_addr_decode #(
        .N_SLAVES  (N_SLAVES),
        .REGION_LO (REGION_LO),
        .REGION_HI (REGION_HI)
    ) u_rd_decode (
        .addr_hi  (bridge_addr[31:24]),
        .hit      (rd_hit),
        .unmapped (rd_unmapped)
    );

    assign wr_go     = bridge_wr & ~wr_unmapped;
    assign sel_n     = req_q.sel[N_SLAVES-1:0];
    assign sel_valid = |(s_rd_valid & sel_n);

    // Selected slave's read data; the select is one-hot so an AND-OR mux suffices
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_data = sel_data | (s_rd_data[32*i +: 32] & {32{sel_n[i]}});
        end
    end

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        cnt_d         = cnt_q;
        rd_data_d     = bridge_rd_data;
        s_addr_d      = s_addr;
        s_wr_data_d   = s_wr_data;
        s_wr_d        = '0;
        s_rd_d        = '0;
        tmo_set       = 1'b0;
        ovr_set       = 1'b0;

        if (wr_go) begin
            s_wr_d      = wr_hit[N_SLAVES-1:0];
            s_addr_d    = bridge_addr;
            s_wr_data_d = bridge_wr_data;
        end

        case (state_q)
            IDLE: begin
                if (bridge_rd) begin
                    if (rd_unmapped) begin
                        rd_data_d = UNMAPPED_DATA;
                    end else begin
                        req_d.addr = bridge_addr;
                        req_d.sel  = rd_hit;
                        state_d    = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                // A write strobe going out next cycle owns s_addr; hold the read one more cycle
                if (!wr_go) begin
                    s_rd_d   = sel_n;
                    s_addr_d = req_q.addr;
                    cnt_d    = '0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (sel_valid) begin
                    rd_data_d = sel_data;
                    state_d   = IDLE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rd_data_d = UNMAPPED_DATA;
                    tmo_set   = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bridge_rd && rd_busy) begin
            ovr_set = 1'b1;
        end

        rd_busy_d     = (state_d != IDLE);
        err_timeout_d = tmo_set | (err_timeout & ~err_clr);
        err_overrun_d = ovr_set | (err_overrun & ~err_clr);
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_q          <= '0;
            cnt_q          <= '0;
            bridge_rd_data <= '0;
            s_addr         <= '0;
            s_wr_data      <= '0;
            s_wr           <= '0;
            s_rd           <= '0;
            rd_busy        <= 1'b0;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            cnt_q          <= cnt_d;
            bridge_rd_data <= rd_data_d;
            s_addr         <= s_addr_d;
            s_wr_data      <= s_wr_data_d;
            s_wr           <= s_wr_d;
            s_rd           <= s_rd_d;
            rd_busy        <= rd_busy_d;
            err_timeout    <= err_timeout_d;
            err_overrun    <= err_overrun_d;
        end
    end

endmodule
